// File: rtl/hit_scorer.sv
// hit_scorer: debounced strike scoring for a timed whack-a-box round; define HIT_SCORER_MISS_PENALTY_EN to make misses cost a point
module hit_scorer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TICKS_PER_SEC = 50000000,
    parameter int GAME_SECONDS = 60
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start_game,
    input  logic [2:0]  box_address,
    input  logic [2:0]  target,
    output logic [10:0] score,
    output logic [5:0]  game_timer,
    output logic        hit_detected,
    output logic        miss_detected,
    output logic        play_sound,
    output logic        lobby_sound,
    output logic        game_over
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
    state_t state, state_next;
    logic [2:0] cand, db_code;
    logic [DW-1:0] db_cnt, db_cnt_next;
    logic [TW-1:0] tick;
    logic accept, strike, sec_wrap, expire, ev, hit, miss, begin_round;
    // debounce run length, strike detection and round timing decisions
    always_comb begin
        db_cnt_next = (box_address != cand) ? DW'(1) : (db_cnt == DW'(DEBOUNCE_CYCLES)) ? db_cnt : db_cnt + DW'(1);
        accept = db_cnt_next == DW'(DEBOUNCE_CYCLES);
        strike = accept && db_code == 3'd0 && box_address != 3'd0;
        sec_wrap = state == PLAY && tick == TW'(TICKS_PER_SEC - 1);
        expire = sec_wrap && game_timer == 6'(GAME_SECONDS - 1);
        ev = strike && state == PLAY && !expire;
        hit = ev && box_address == target;
        miss = ev && box_address != target;
        begin_round = state == IDLE && start_game;
    end
    // next state and state-decoded outputs
    always_comb begin
        state_next = begin_round ? PLAY : expire ? OVER : (state == OVER && start_game) ? IDLE : state;
        lobby_sound = state == IDLE;
        game_over = state == OVER;
        play_sound = hit_detected;
    end
    // state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    // debounce: accept a code once it has been seen on DEBOUNCE_CYCLES consecutive samples
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cand <= 3'd0;
            db_cnt <= '0;
            db_code <= 3'd0;
        end else begin
            cand <= box_address;
            db_cnt <= db_cnt_next;
            if (accept) db_code <= box_address;
        end
    end
    // round timer: tick counter and elapsed seconds, frozen outside PLAY
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tick <= '0;
            game_timer <= 6'd0;
        end else if (begin_round) begin
            tick <= '0;
            game_timer <= 6'd0;
        end else if (state == PLAY) begin
            tick <= sec_wrap ? '0 : tick + TW'(1);
            if (sec_wrap) game_timer <= game_timer + 6'd1;
        end
    end
    // score and hit/miss pulses
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            score <= 11'd0;
            hit_detected <= 1'b0;
            miss_detected <= 1'b0;
        end else begin
            hit_detected <= hit;
            miss_detected <= miss;
            if (begin_round) score <= 11'd0;
            else if (hit && score != 11'd2047) score <= score + 11'd1;
`ifdef HIT_SCORER_MISS_PENALTY_EN
            else if (miss && score != 11'd0) score <= score - 11'd1;
`else
            else score <= score;
`endif
        end
    end
endmodule
